tx_source_arbiter: RTL and testbench

Shares the single Ethernet transmit path among N protocol senders (ICMP echo, ARP, UDP, DHCP, …) in the `tx_clock` domain. Each sender raises a level `tx_request` and waits for a one-cycle `tx_enable`. The arbiter picks one requester by round-robin and pulses its enable. It then steers that sender's byte stream and frame metadata (length, destination MAC/IP) to the MAC/IP header builder, and enforces an inter-frame gap and a start-of-frame timeout.

---
 rtl/tx_source_arbiter_if.sv | 35 +++
 rtl/tx_source_arbiter.sv | 178 +++++++++++++++++
 tb/tb_tx_source_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_source_arbiter_if.sv
// tx_source_arbiter_if: per-source request/stream/metadata bundle feeding the
// arbiter, and the merged stream plus status it hands to the header builder.
interface tx_source_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    src_request;
  logic [N-1:0]    src_active;
  logic [8*N-1:0]  src_data;
  logic [16*N-1:0] src_length;
  logic [48*N-1:0] src_mac;
  logic [32*N-1:0] src_ip;
  logic [N-1:0]    src_enable;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [15:0]     out_length;
  logic [47:0]     out_mac;
  logic [31:0]     out_ip;
  logic [2:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  // The arbiter owns the shared path
  modport master (
    input  src_request, src_active, src_data, src_length, src_mac, src_ip,
    output src_enable, out_valid, out_data, out_length, out_mac, out_ip,
           grant_id, busy, timeout_err
  );

  // Senders and the downstream header builder
  modport slave (
    output src_request, src_active, src_data, src_length, src_mac, src_ip,
    input  src_enable, out_valid, out_data, out_length, out_mac, out_ip,
           grant_id, busy, timeout_err
  );
endinterface

// File: rtl/tx_source_arbiter.sv
// tx_source_arbiter: round-robin owner of the single Ethernet transmit path.
// A requester is chosen in IDLE, gets a one-cycle enable in GRANT, streams
// during ACTIVE, and the path is then held idle for IFG cycles in GAP. A
// sender that never starts its frame is abandoned after TIMEOUT cycles.
module tx_source_arbiter #(
  parameter int N       = 4,
  parameter int IFG     = 12,
  parameter int TIMEOUT = 64
) (
  input logic                 tx_clock,
  input logic                 reset,
  tx_source_arbiter_if.master arb
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GRANT  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]   r_state;
  logic [2:0]   r_last;
  logic [2:0]   r_grantId;
  logic         r_seen;
  logic [15:0]  r_count;
  logic [15:0]  r_length;
  logic [47:0]  r_mac;
  logic [31:0]  r_ip;
  logic         r_valid;
  logic [7:0]   r_data;

  logic [N-1:0] w_rotated;
  logic [2:0]   w_offset;
  logic         w_found;
  logic [3:0]   w_sum;
  logic [2:0]   w_pick;
  logic [15:0]  w_pickLength;
  logic [47:0]  w_pickMac;
  logic [31:0]  w_pickIp;
  logic         w_grantActive;
  logic [7:0]   w_grantData;
  logic [N-1:0] w_grantHot;
  logic         w_live;
  logic         w_timeout;

  // Round-robin search: rotate requests so bit 0 is the source after the
  // last winner, take the lowest set bit, then map back to a source index
  always_comb begin
    w_rotated = N'({arb.src_request, arb.src_request} >> (r_last + 3'd1));
    w_found   = 1'b0;
    w_offset  = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rotated[k]) begin
        w_found  = 1'b1;
        w_offset = 3'(k);
      end
    end
    w_sum = {1'b0, r_last} + 4'd1 + {1'b0, w_offset};
    if (w_sum >= 4'(N)) begin
      w_sum = w_sum - 4'(N);
    end
    w_pick = w_sum[2:0];
  end

  // Metadata of the source about to be granted, captured on the IDLE edge
  always_comb begin
    w_pickLength = '0;
    w_pickMac    = '0;
    w_pickIp     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick == 3'(i)) begin
        w_pickLength = arb.src_length[16*i +: 16];
        w_pickMac    = arb.src_mac[48*i +: 48];
        w_pickIp     = arb.src_ip[32*i +: 32];
      end
    end
  end

  // Stream and activity of the current grantee
  always_comb begin
    w_grantActive = 1'b0;
    w_grantData   = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grantId == 3'(i)) begin
        w_grantActive = arb.src_active[i];
        w_grantData   = arb.src_data[8*i +: 8];
      end
    end
  end

  assign w_grantHot = {{(N-1){1'b0}}, 1'b1} << r_grantId;
  assign w_live     = (r_state == S_GRANT) || (r_state == S_ACTIVE);

  // The start-of-frame timer reaching its last count is the timeout event;
  // it depends only on registers so the pulse is glitch-free
  assign w_timeout  = (r_state == S_ACTIVE) && !r_seen && (r_count == 16'd1);

  // Arbitration FSM with grant bookkeeping, frame tracking and gap timing
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_last    <= 3'(N - 1);
      r_grantId <= 3'd0;
      r_seen    <= 1'b0;
      r_count   <= 16'd0;
      r_length  <= 16'd0;
      r_mac     <= 48'd0;
      r_ip      <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grantId <= w_pick;
            r_last    <= w_pick;
            r_length  <= w_pickLength;
            r_mac     <= w_pickMac;
            r_ip      <= w_pickIp;
            r_state   <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_seen  <= 1'b0;
          r_count <= 16'(TIMEOUT);
          r_state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_grantActive) begin
            r_seen <= 1'b1;
          end
          if (r_seen) begin
            if (!w_grantActive) begin
              r_state <= S_GAP;
              r_count <= 16'(IFG);
            end
          end else if (r_count == 16'd1) begin
            r_state <= S_GAP;
            r_count <= 16'(IFG);
          end else begin
            r_count <= r_count - 16'd1;
          end
        end
        S_GAP: begin
          if (r_count <= 16'd1) begin
            r_state <= S_IDLE;
            r_count <= 16'd0;
          end else begin
            r_count <= r_count - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // One-cycle registered copy of the grantee's stream, forced quiet when no
  // frame is in progress
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= 8'd0;
    end else begin
      r_valid <= w_grantActive & w_live;
      r_data  <= w_live ? w_grantData : 8'd0;
    end
  end

  assign arb.src_enable  = (r_state == S_GRANT) ? w_grantHot : '0;
  assign arb.out_valid   = r_valid;
  assign arb.out_data    = r_data;
  assign arb.out_length  = r_length;
  assign arb.out_mac     = r_mac;
  assign arb.out_ip      = r_ip;
  assign arb.grant_id    = r_grantId;
  assign arb.busy        = (r_state != S_IDLE);
  assign arb.timeout_err = w_timeout;

endmodule

// File: tb/tb_tx_source_arbiter.sv
// tb_tx_source_arbiter: directed scenarios plus randomized senders, checked
// every cycle against a behavioural model of the arbitration rules.
module tb_tx_source_arbiter;

  localparam int N       = 4;
  localparam int IFG     = 12;
  localparam int TIMEOUT = 64;

  logic tx_clock = 1'b0;
  logic reset    = 1'b1;

  tx_source_arbiter_if #(.N(N)) arb();

  tx_source_arbiter #(.N(N), .IFG(IFG), .TIMEOUT(TIMEOUT)) dut (
    .tx_clock (tx_clock),
    .reset    (reset),
    .arb      (arb)
  );

  always #5 tx_clock = ~tx_clock;

  int vectors     = 0;
  int miscompares = 0;

  // Sender models
  int remain[N];
  int frameLen[N];
  bit silent[N];
  bit randomMode = 1'b0;

  // Observations of the DUT
  int edgeCount   = 0;
  int enCount[N];
  int orderQ[$];
  int enTimeQ[$];
  int toTimeQ[$];
  int validCycles = 0;

  // Reference model
  int          mLast, mGid, mGapLeft, mWaited, mPick;
  bit          mGranting, mInFrame, mSeen, mValid, mAct, mLive;
  logic [7:0]  mData;
  logic [15:0] mLen;
  logic [47:0] mMac;
  logic [31:0] mIp;
  logic [N-1:0] expEn;

  function automatic int rrPick(input logic [N-1:0] req, input int last);
    for (int s = 1; s <= N; s++) begin
      int c;
      c = (last + s) % N;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  function automatic int qAt(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: frame lifecycle expressed as grant/frame/gap bookkeeping
  always @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      mLast = N - 1; mGid = 0; mGapLeft = 0; mWaited = 0;
      mGranting = 0; mInFrame = 0; mSeen = 0; mValid = 0;
      mData = '0; mLen = '0; mMac = '0; mIp = '0;
    end else begin
      mAct  = arb.src_active[mGid];
      mLive = mGranting || mInFrame;
      mValid = mAct && mLive;
      mData  = mLive ? arb.src_data[8*mGid +: 8] : 8'h00;
      if (mGranting) begin
        mGranting = 0; mInFrame = 1; mSeen = 0; mWaited = 0;
      end else if (mInFrame) begin
        if (mSeen && !mAct) begin
          mInFrame = 0; mGapLeft = IFG;
        end else if (!mSeen && mWaited == TIMEOUT - 1) begin
          mInFrame = 0; mGapLeft = IFG;
        end else if (!mSeen) begin
          mWaited++;
        end
        if (mAct) mSeen = 1;
      end else if (mGapLeft > 0) begin
        mGapLeft--;
      end else if (arb.src_request != '0) begin
        mPick = rrPick(arb.src_request, mLast);
        mLast = mPick; mGid = mPick; mGranting = 1;
        mLen = arb.src_length[16*mPick +: 16];
        mMac = arb.src_mac[48*mPick +: 48];
        mIp  = arb.src_ip[32*mPick +: 32];
      end
    end
  end

  // Per-cycle compare against the model, plus event logging
  always @(posedge tx_clock) begin
    #1;
    edgeCount++;
    expEn = mGranting ? (N'(1) << mGid) : '0;
    checkOutput("src_enable",  64'(arb.src_enable),  64'(expEn));
    checkOutput("busy",        64'(arb.busy),        64'(mGranting || mInFrame || (mGapLeft > 0)));
    checkOutput("timeout_err", 64'(arb.timeout_err), 64'(mInFrame && !mSeen && (mWaited == TIMEOUT - 1)));
    checkOutput("grant_id",    64'(arb.grant_id),    64'(mGid));
    checkOutput("out_length",  64'(arb.out_length),  64'(mLen));
    checkOutput("out_mac",     64'(arb.out_mac),     64'(mMac));
    checkOutput("out_ip",      64'(arb.out_ip),      64'(mIp));
    checkOutput("out_valid",   64'(arb.out_valid),   64'(mValid));
    checkOutput("out_data",    64'(arb.out_data),    64'(mData));
    for (int i = 0; i < N; i++) begin
      if (arb.src_enable[i]) begin
        enCount[i]++;
        orderQ.push_back(i);
        enTimeQ.push_back(edgeCount);
      end
    end
    if (arb.timeout_err) toTimeQ.push_back(edgeCount);
    if (arb.out_valid) validCycles++;
  end

  // One cycle of sender behaviour, driven mid-cycle
  task automatic applyStimulus();
    @(negedge tx_clock);
    for (int i = 0; i < N; i++) begin
      if (arb.src_enable[i]) begin
        arb.src_request[i] = 1'b0;
        if (!silent[i]) remain[i] = frameLen[i];
      end
      arb.src_active[i] = (remain[i] > 0);
      if (remain[i] > 0) remain[i]--;
      arb.src_data[8*i +: 8] = 8'($urandom);
      if (randomMode) begin
        if (!arb.src_request[i] && remain[i] == 0 && !arb.src_enable[i] && $urandom_range(0, 15) == 0) begin
          frameLen[i] = $urandom_range(2, 20);
          silent[i]   = ($urandom_range(0, 9) == 0);
          arb.src_length[16*i +: 16] = 16'($urandom);
          arb.src_mac[48*i +: 48]    = 48'({$urandom, $urandom});
          arb.src_ip[32*i +: 32]     = $urandom;
          arb.src_request[i] = 1'b1;
        end else if (arb.src_request[i] && $urandom_range(0, 63) == 0) begin
          arb.src_request[i] = 1'b0;
        end
        if ($urandom_range(0, 31) == 0) arb.src_mac[48*i +: 48] = 48'({$urandom, $urandom});
        if ($urandom_range(0, 31) == 0) arb.src_length[16*i +: 16] = 16'($urandom);
      end
    end
  endtask

  task automatic waitQuiet(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!(arb.busy == 1'b0 && arb.src_request == '0) && n < budget);
    if (!(arb.busy == 1'b0 && arb.src_request == '0)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: still busy after %0d cycles, expected idle", tag, budget);
    end
  endtask

  task automatic waitGrants(input string tag, input int count, input int budget);
    int n;
    n = 0;
    while (orderQ.size() < count && n < budget) begin
      applyStimulus();
      n++;
    end
    if (orderQ.size() < count) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: %0d grants seen, expected %0d", tag, orderQ.size(), count);
    end
  endtask

  task automatic clearLogs();
    orderQ.delete();
    enTimeQ.delete();
    toTimeQ.delete();
    validCycles = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      remain[i] = 0; silent[i] = 0; frameLen[i] = 10;
    end
    arb.src_request = '0;
    arb.src_active  = '0;
    repeat (3) applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    int en1;
    arb.src_request = '0;
    arb.src_active  = '0;
    arb.src_data    = '0;
    arb.src_length  = '0;
    arb.src_mac     = '0;
    arb.src_ip      = '0;
    for (int i = 0; i < N; i++) enCount[i] = 0;
    doReset();
    checkOutput("reset busy",     64'(arb.busy),       64'(0));
    checkOutput("reset grant_id", 64'(arb.grant_id),   64'(0));
    checkOutput("reset enable",   64'(arb.src_enable), 64'(0));

    // Single long frame from source 2
    $display("[TB] single source 2 frame");
    clearLogs();
    arb.src_length[16*2 +: 16] = 16'h0040;
    frameLen[2] = 68;
    arb.src_request[2] = 1'b1;
    waitQuiet("single frame", 300);
    checkOutput("s2 enable pulses", 64'(enCount[2]),       64'(1));
    checkOutput("s2 grantee",       64'(qAt(orderQ, 0)),   64'(2));
    checkOutput("s2 out_length",    64'(arb.out_length),   64'(16'h0040));
    checkOutput("s2 valid cycles",  64'(validCycles),      64'(68));

    // All four at once after reset
    $display("[TB] four simultaneous requesters");
    doReset();
    clearLogs();
    arb.src_request = 4'b1111;
    waitGrants("all4 first grant", 1, 20);
    arb.src_request[0] = 1'b1;
    waitQuiet("all4 frames", 400);
    checkOutput("all4 order0", 64'(qAt(orderQ, 0)), 64'(0));
    checkOutput("all4 order1", 64'(qAt(orderQ, 1)), 64'(1));
    checkOutput("all4 order2", 64'(qAt(orderQ, 2)), 64'(2));
    checkOutput("all4 order3", 64'(qAt(orderQ, 3)), 64'(3));
    checkOutput("all4 order4", 64'(qAt(orderQ, 4)), 64'(0));
    for (int k = 0; k < 4; k++) begin
      checkOutput("all4 grant spacing", 64'(qAt(enTimeQ, k + 1) - qAt(enTimeQ, k)), 64'(24));
    end

    // Rotation with a late higher-priority arrival
    $display("[TB] rotation with late arrival");
    clearLogs();
    arb.src_request[1] = 1'b1;
    waitQuiet("rot prime", 100);
    arb.src_request[1] = 1'b1;
    arb.src_request[3] = 1'b1;
    waitGrants("rot second", 2, 40);
    arb.src_request[0] = 1'b1;
    waitQuiet("rot frames", 300);
    checkOutput("rot order0", 64'(qAt(orderQ, 0)), 64'(1));
    checkOutput("rot order1", 64'(qAt(orderQ, 1)), 64'(3));
    checkOutput("rot order2", 64'(qAt(orderQ, 2)), 64'(0));
    checkOutput("rot order3", 64'(qAt(orderQ, 3)), 64'(1));

    // Silent grantee triggers the start-of-frame timeout
    $display("[TB] timeout");
    clearLogs();
    silent[2] = 1'b1;
    arb.src_request[2] = 1'b1;
    waitGrants("to grant", 1, 20);
    arb.src_request[0] = 1'b1;
    waitQuiet("to frames", 300);
    silent[2] = 1'b0;
    checkOutput("to pulses",      64'(toTimeQ.size()),                         64'(1));
    checkOutput("to delay",       64'(qAt(toTimeQ, 0) - qAt(enTimeQ, 0)),      64'(TIMEOUT));
    checkOutput("to next grantee", 64'(qAt(orderQ, 1)),                        64'(0));
    checkOutput("to next delay",  64'(qAt(enTimeQ, 1) - qAt(toTimeQ, 0)),      64'(IFG + 2));

    // Asynchronous reset in the middle of a frame from source 1
    $display("[TB] reset mid-frame");
    clearLogs();
    arb.src_length[16*1 +: 16] = 16'h1234;
    frameLen[1] = 30;
    arb.src_request[1] = 1'b1;
    waitGrants("rst grant", 1, 20);
    repeat (5) applyStimulus();
    @(posedge tx_clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rst busy",       64'(arb.busy),       64'(0));
    checkOutput("rst enable",     64'(arb.src_enable), 64'(0));
    checkOutput("rst out_valid",  64'(arb.out_valid),  64'(0));
    checkOutput("rst out_length", 64'(arb.out_length), 64'(0));
    checkOutput("rst out_data",   64'(arb.out_data),   64'(0));
    remain[1] = 0;
    arb.src_active[1]  = 1'b0;
    arb.src_request[1] = 1'b1;
    clearLogs();
    en1 = enCount[1];
    repeat (2) applyStimulus();
    reset = 1'b0;
    waitQuiet("rst regrant", 200);
    checkOutput("rst regrant id",     64'(qAt(orderQ, 0)),   64'(1));
    checkOutput("rst regrant pulses", 64'(enCount[1] - en1), 64'(1));

    // Metadata changing under an active frame
    $display("[TB] metadata hold");
    clearLogs();
    arb.src_mac[48*0 +: 48] = 48'h112233445566;
    frameLen[0] = 20;
    arb.src_request[0] = 1'b1;
    waitGrants("mac grant", 1, 20);
    repeat (3) applyStimulus();
    arb.src_mac[48*0 +: 48] = 48'h0;
    repeat (5) applyStimulus();
    checkOutput("mac mid-frame", 64'(arb.out_mac), 64'(48'h112233445566));
    waitQuiet("mac frame", 100);
    checkOutput("mac after frame", 64'(arb.out_mac), 64'(48'h112233445566));
    arb.src_request[0] = 1'b1;
    waitGrants("mac regrant", 2, 20);
    checkOutput("mac next grant", 64'(arb.out_mac), 64'(0));
    waitQuiet("mac refrane", 100);

    // Randomized senders
    $display("[TB] randomized traffic");
    randomMode = 1'b1;
    repeat (3000) applyStimulus();
    randomMode = 1'b0;
    waitQuiet("drain", 800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
